// File: rtl/tri_bus_arbiter_if.sv
// Bus-side signal bundle for the tri-state bus arbiter: requests in,
// per-driver direction enables and status out.
interface tri_bus_arbiter_if #(
   parameter int N = 4
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic [PW-1:0] owner;
   logic          turn;
   logic          hold_expired;

   // Arbiter side
   modport master (
      input  req,
      output grant,
      output owner,
      output turn,
      output hold_expired
   );

   // Requester side
   modport slave (
      output req,
      input  grant,
      input  owner,
      input  turn,
      input  hold_expired
   );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus. Owns every driver
// enable, keeps at most one enabled, inserts TURN_CYC all-off cycles between
// owners and forces a release after MAX_HOLD drive cycles (0 = unlimited).
module tri_bus_arbiter #(
   parameter int N        = 4,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                rst,
   tri_bus_arbiter_if.master   bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

   localparam logic [HW-1:0] MAX_HOLD_W = HW'(MAX_HOLD);
   localparam logic [TW-1:0] TURN_CYC_W = TW'(TURN_CYC);
   localparam logic [PW-1:0] LAST_IDX   = PW'(N - 1);
   localparam logic [N-1:0]  ONE_N      = N'(1);

   typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] owner_q, owner_d;
   logic          turn_q, turn_d;
   logic          hold_expired_q, hold_expired_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [TW-1:0] turn_cnt_q, turn_cnt_d;

   logic          own_req;
   logic          hold_limit;
   logic          turn_last;
   logic [PW-1:0] winner;

   // First requester at or after p, wrapping modulo N. Rotating the request
   // vector right by p turns the search into a plain lowest-set-bit scan.
   function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [PW-1:0] p);
      logic [2*N-1:0] dbl;
      logic           found;
      int             off;
      dbl   = {r, r} >> p;
      found = 1'b0;
      off   = 0;
      for (int k = 0; k < N; k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      return PW'((int'(p) + off) % N);
   endfunction

   assign own_req    = bus.req[owner_q];
   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_W);
   assign turn_last  = (turn_cnt_q == TURN_CYC_W);
   assign winner     = rr_pick(bus.req, ptr_q);

   // State and output registers; reset drops the bus immediately with no turnaround
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         grant_q        <= '0;
         owner_q        <= '0;
         turn_q         <= 1'b0;
         hold_expired_q <= 1'b0;
         ptr_q          <= '0;
         hold_cnt_q     <= '0;
         turn_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         owner_q        <= owner_d;
         turn_q         <= turn_d;
         hold_expired_q <= hold_expired_d;
         ptr_q          <= ptr_d;
         hold_cnt_q     <= hold_cnt_d;
         turn_cnt_q     <= turn_cnt_d;
      end
   end

   // Next-state: other requesters are ignored while an owner drives
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|bus.req) state_d = DRIVE;
         DRIVE:   if (!own_req || hold_limit) state_d = TURN;
         TURN:    if (turn_last) state_d = (|bus.req) ? DRIVE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, pointer and counters for the chosen transition
   always_comb begin
      grant_d        = grant_q;
      owner_d        = owner_q;
      turn_d         = 1'b0;
      hold_expired_d = 1'b0;
      ptr_d          = ptr_q;
      hold_cnt_d     = hold_cnt_q;
      turn_cnt_d     = turn_cnt_q;

      if (state_q != DRIVE && state_d == DRIVE) begin
         // New grant from IDLE or from the final turnaround cycle
         grant_d    = ONE_N << winner;
         owner_d    = winner;
         hold_cnt_d = HW'(1);
      end else if (state_q == DRIVE && state_d == TURN) begin
         // Release: still requesting here means the hold limit forced it
         grant_d        = '0;
         turn_d         = 1'b1;
         hold_expired_d = own_req;
         ptr_d          = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
         turn_cnt_d     = TW'(1);
      end else if (state_q == DRIVE) begin
         if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HW'(1);
      end else if (state_q == TURN && state_d == TURN) begin
         turn_d     = 1'b1;
         turn_cnt_d = turn_cnt_q + TW'(1);
      end
   end

   assign bus.grant        = grant_q;
   assign bus.owner        = owner_q;
   assign bus.turn         = turn_q;
   assign bus.hold_expired = hold_expired_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed and random-invariant bench for tri_bus_arbiter (N=4, TURN_CYC=1,
// MAX_HOLD=8). Inputs change on the falling edge, outputs are read there too.
module tb_tri_bus_arbiter;
   localparam int N        = 4;
   localparam int TURN_CYC = 1;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tri_bus_arbiter_if #(.N(N)) bus ();

   tri_bus_arbiter #(
      .N        (N),
      .TURN_CYC (TURN_CYC),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      step();
      rst     = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.req = 4'b1111;
      step();
      step();
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant);
      end
      checks++;
      if (bus.turn !== 1'b0) begin
         errors++; $display("FAIL reset_turn: got %b expected 0", bus.turn);
      end
      checks++;
      if (bus.owner !== 2'd0) begin
         errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner);
      end
      checks++;
      if (bus.hold_expired !== 1'b0) begin
         errors++; $display("FAIL reset_hold_expired: got %b expected 0", bus.hold_expired);
      end
      rst     = 1'b0;
      bus.req = '0;
      step();
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++; $display("FAIL idle_no_req: got %b expected 0000", bus.grant);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 4'b0100;
      step();
      checks++;
      if (bus.grant !== 4'b0100) begin
         errors++; $display("FAIL single_grant: got %b expected 0100", bus.grant);
      end
      checks++;
      if (bus.owner !== 2'd2) begin
         errors++; $display("FAIL single_owner: got %0d expected 2", bus.owner);
      end
      bus.req = 4'b0000;
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.turn !== 1'b1) begin
         errors++; $display("FAIL single_release: grant %b turn %b expected 0000 1", bus.grant, bus.turn);
      end
      checks++;
      if (bus.hold_expired !== 1'b0) begin
         errors++; $display("FAIL single_no_expire: got %b expected 0", bus.hold_expired);
      end
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.turn !== 1'b0) begin
         errors++; $display("FAIL single_idle: grant %b turn %b expected 0000 0", bus.grant, bus.turn);
      end
      checks++;
      if (bus.owner !== 2'd2) begin
         errors++; $display("FAIL single_owner_hold: got %0d expected 2", bus.owner);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      logic [1:0] exp_o;
      do_reset();
      bus.req = 4'b1111;
      step();
      for (int g = 0; g < 5; g++) begin
         exp_o = 2'(g % 4);
         exp_g = 4'b0001 << exp_o;
         for (int c = 0; c < MAX_HOLD; c++) begin
            checks++;
            if (bus.grant !== exp_g || bus.owner !== exp_o) begin
               errors++;
               $display("FAIL rr_grant g%0d c%0d: grant %b owner %0d expected %b %0d",
                        g, c, bus.grant, bus.owner, exp_g, exp_o);
            end
            step();
         end
         checks++;
         if (bus.grant !== 4'b0000 || bus.turn !== 1'b1 || bus.hold_expired !== 1'b1) begin
            errors++;
            $display("FAIL rr_gap g%0d: grant %b turn %b hold_expired %b expected 0000 1 1",
                     g, bus.grant, bus.turn, bus.hold_expired);
         end
         step();
         checks++;
         if (bus.hold_expired !== 1'b0 || bus.turn !== 1'b0) begin
            errors++;
            $display("FAIL rr_pulse_len g%0d: hold_expired %b turn %b expected 0 0",
                     g, bus.hold_expired, bus.turn);
         end
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_handover();
      do_reset();
      bus.req = 4'b0010;
      step();
      checks++;
      if (bus.grant !== 4'b0010) begin
         errors++; $display("FAIL handover_first: got %b expected 0010", bus.grant);
      end
      bus.req = 4'b1001;
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.turn !== 1'b1) begin
         errors++; $display("FAIL handover_gap: grant %b turn %b expected 0000 1", bus.grant, bus.turn);
      end
      step();
      checks++;
      if (bus.grant !== 4'b1000 || bus.owner !== 2'd3) begin
         errors++; $display("FAIL handover_next: grant %b owner %0d expected 1000 3", bus.grant, bus.owner);
      end
      checks++;
      if (bus.turn !== 1'b0) begin
         errors++; $display("FAIL handover_turn_off: got %b expected 0", bus.turn);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_reset_mid_drive();
      do_reset();
      bus.req = 4'b0010;
      step();
      checks++;
      if (bus.grant !== 4'b0010) begin
         errors++; $display("FAIL rstmid_pre: got %b expected 0010", bus.grant);
      end
      rst     = 1'b1;
      bus.req = 4'b0011;
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.turn !== 1'b0 || bus.owner !== 2'd0) begin
         errors++; $display("FAIL rstmid_drop: grant %b turn %b owner %0d expected 0000 0 0",
                            bus.grant, bus.turn, bus.owner);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.owner !== 2'd0) begin
         errors++; $display("FAIL rstmid_regrant: grant %b owner %0d expected 0001 0", bus.grant, bus.owner);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_sole_requester_regrant();
      do_reset();
      bus.req = 4'b0001;
      step();
      for (int c = 1; c < MAX_HOLD; c++) step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.hold_expired !== 1'b0) begin
         errors++; $display("FAIL sole_last_cycle: grant %b hold_expired %b expected 0001 0",
                            bus.grant, bus.hold_expired);
      end
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.hold_expired !== 1'b1) begin
         errors++; $display("FAIL sole_preempt: grant %b hold_expired %b expected 0000 1",
                            bus.grant, bus.hold_expired);
      end
      step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.owner !== 2'd0) begin
         errors++; $display("FAIL sole_regrant: grant %b owner %0d expected 0001 0", bus.grant, bus.owner);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_random_invariant();
      logic [3:0] prev_grant;
      int         zero_run;
      int         run_len;
      logic       seen_nz;
      do_reset();
      prev_grant = '0;
      zero_run   = 0;
      run_len    = 0;
      seen_nz    = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
         step();
         checks++;
         if ($countones(bus.grant) > 1) begin
            errors++; $display("FAIL inv_onehot cyc%0d: got %b expected at most one bit", cyc, bus.grant);
         end
         checks++;
         if (bus.turn === 1'b1 && bus.grant !== 4'b0000) begin
            errors++; $display("FAIL inv_turn_grant cyc%0d: grant %b expected 0000 while turn", cyc, bus.grant);
         end
         if (bus.grant !== 4'b0000) begin
            checks++;
            if (bus.grant !== (4'b0001 << bus.owner)) begin
               errors++; $display("FAIL inv_owner cyc%0d: grant %b owner %0d", cyc, bus.grant, bus.owner);
            end
            if (prev_grant !== 4'b0000) begin
               checks++;
               if (bus.grant !== prev_grant) begin
                  errors++; $display("FAIL inv_switch cyc%0d: got %b after %b expected gap", cyc, bus.grant, prev_grant);
               end
               run_len++;
            end else begin
               if (seen_nz) begin
                  checks++;
                  if (zero_run < TURN_CYC) begin
                     errors++; $display("FAIL inv_gap cyc%0d: got %0d idle cycles expected >= %0d",
                                        cyc, zero_run, TURN_CYC);
                  end
               end
               run_len = 1;
            end
            checks++;
            if (run_len > MAX_HOLD) begin
               errors++; $display("FAIL inv_hold cyc%0d: got %0d drive cycles expected <= %0d",
                                  cyc, run_len, MAX_HOLD);
            end
            zero_run = 0;
            seen_nz  = 1'b1;
         end else begin
            zero_run++;
         end
         prev_grant = bus.grant;
      end
      bus.req = '0;
      step();
      step();
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_handover();
      test_reset_mid_drive();
      test_sole_requester_regrant();
      test_random_invariant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
